// File: rtl/error_report_formatter.sv
// error_report_formatter
//   Latches a packed vector of per-tap IDELAY sweep error counts on I_STB and
//   streams it as uppercase ASCII hex lines "TT:C..C\r\n", one per tap, tap 0
//   first, over a byte valid/ready interface.
//
//   Optional feature: define ERROR_REPORT_SUMMARY_EN to also track the tap with
//   the lowest count (lowest index wins ties) and append a line "B:TT\r\n".
//
// Ports
//   CLK       clock, all state on rising edge
//   RST       synchronous active-high reset (highest priority)
//   I_STB     one-cycle strobe, I_DAT holds a complete sweep
//   I_DAT     packed counts, tap 0 in the most-significant slot
//   O_STB     output byte valid
//   O_DAT     output ASCII byte
//   O_RDY     sink ready; byte transfers on a rising edge with O_STB && O_RDY
//   BUSY      high from latch until the last byte has transferred
//   DROP_CNT  saturating count of I_STB pulses ignored while BUSY
module error_report_formatter #(
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned DELAY_TAPS  = 32
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              I_STB,
  input  logic [COUNT_WIDTH*DELAY_TAPS-1:0] I_DAT,
  output logic                              O_STB,
  output logic [7:0]                        O_DAT,
  input  logic                              O_RDY,
  output logic                              BUSY,
  output logic [7:0]                        DROP_CNT
);

  localparam int unsigned TOTAL      = COUNT_WIDTH * DELAY_TAPS;
  localparam int unsigned CNT_DIGITS = COUNT_WIDTH / 4;
  localparam int unsigned DW         = (CNT_DIGITS > 1) ? $clog2(CNT_DIGITS) : 1;
  localparam logic [DW-1:0] DIG_LAST = DW'(CNT_DIGITS - 1);
  localparam logic [7:0]    LAST_TAP = 8'(DELAY_TAPS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_TAP_HI,
    S_TAP_LO,
    S_SEP,
    S_CNT,
    S_CR,
    S_LF
`ifdef ERROR_REPORT_SUMMARY_EN
    , S_SUMMARY
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TOTAL-1:0]  r_shadow;
  logic [7:0]        r_tap;
  logic [DW-1:0]     r_dig;
  logic [7:0]        r_drop;
  logic              w_xfer;
  logic              w_last_tap;
  logic [COUNT_WIDTH-1:0] w_cur;
  logic [3:0]        w_nib;
  logic [TOTAL-1:0]  w_shift;

`ifdef ERROR_REPORT_SUMMARY_EN
  logic [COUNT_WIDTH-1:0] r_min;
  logic [7:0]             r_min_tap;
  logic [2:0]             r_sidx;
  logic [COUNT_WIDTH-1:0] w_next_cnt;
`endif

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // The shadow register shifts one slot per tap, so the current tap's count
  // is always the most-significant slot.
  assign w_cur      = r_shadow[TOTAL-1 -: COUNT_WIDTH];
  assign w_shift    = r_shadow << COUNT_WIDTH;
  assign w_nib      = 4'(w_cur >> {r_dig, 2'b00});
  assign w_last_tap = (r_tap == LAST_TAP);
  assign w_xfer     = O_STB && O_RDY;
  assign DROP_CNT   = r_drop;
`ifdef ERROR_REPORT_SUMMARY_EN
  assign w_next_cnt = w_shift[TOTAL-1 -: COUNT_WIDTH];
`endif

  always_comb begin
    w_state_nxt = r_state;
    O_STB       = 1'b1;
    O_DAT       = '0;
    BUSY        = 1'b1;
    case (r_state)
      S_IDLE: begin
        O_STB = 1'b0;
        BUSY  = 1'b0;
        if (I_STB) w_state_nxt = S_TAP_HI;
      end
      S_TAP_HI: begin
        O_DAT = hex(r_tap[7:4]);
        if (O_RDY) w_state_nxt = S_TAP_LO;
      end
      S_TAP_LO: begin
        O_DAT = hex(r_tap[3:0]);
        if (O_RDY) w_state_nxt = S_SEP;
      end
      S_SEP: begin
        O_DAT = 8'h3A;
        if (O_RDY) w_state_nxt = S_CNT;
      end
      S_CNT: begin
        O_DAT = hex(w_nib);
        if (O_RDY && (r_dig == '0)) w_state_nxt = S_CR;
      end
      S_CR: begin
        O_DAT = 8'h0D;
        if (O_RDY) w_state_nxt = S_LF;
      end
      S_LF: begin
        O_DAT = 8'h0A;
        if (O_RDY) begin
          if (!w_last_tap)
            w_state_nxt = S_TAP_HI;
          else
`ifdef ERROR_REPORT_SUMMARY_EN
            w_state_nxt = S_SUMMARY;
`else
            w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef ERROR_REPORT_SUMMARY_EN
      S_SUMMARY: begin
        case (r_sidx)
          3'd0:    O_DAT = 8'h42;
          3'd1:    O_DAT = 8'h3A;
          3'd2:    O_DAT = hex(r_min_tap[7:4]);
          3'd3:    O_DAT = hex(r_min_tap[3:0]);
          3'd4:    O_DAT = 8'h0D;
          default: O_DAT = 8'h0A;
        endcase
        if (O_RDY && (r_sidx == 3'd5)) w_state_nxt = S_IDLE;
      end
`endif
      default: begin
        O_STB       = 1'b0;
        BUSY        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_tap    <= '0;
      r_dig    <= '0;
      r_drop   <= '0;
`ifdef ERROR_REPORT_SUMMARY_EN
      r_min     <= '0;
      r_min_tap <= '0;
      r_sidx    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;

      if (I_STB && BUSY && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;

      if ((r_state == S_IDLE) && I_STB) begin
        r_shadow <= I_DAT;
        r_tap    <= '0;
        r_dig    <= DIG_LAST;
`ifdef ERROR_REPORT_SUMMARY_EN
        // Tap 0 enters TAP_HI with nothing to compare against: it seeds the minimum.
        r_min     <= I_DAT[TOTAL-1 -: COUNT_WIDTH];
        r_min_tap <= '0;
        r_sidx    <= '0;
`endif
      end

      if (w_xfer) begin
        case (r_state)
          S_CNT: if (r_dig != '0) r_dig <= r_dig - 1'b1;
          S_LF: begin
            if (!w_last_tap) begin
              r_tap    <= r_tap + 8'd1;
              r_shadow <= w_shift;
              r_dig    <= DIG_LAST;
`ifdef ERROR_REPORT_SUMMARY_EN
              // Strict less-than keeps the lower tap index on ties.
              if (w_next_cnt < r_min) begin
                r_min     <= w_next_cnt;
                r_min_tap <= r_tap + 8'd1;
              end
`endif
            end
          end
`ifdef ERROR_REPORT_SUMMARY_EN
          S_SUMMARY: r_sidx <= r_sidx + 3'd1;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_error_report_formatter.sv
module tb_error_report_formatter;

  localparam int unsigned CW = 24;
  localparam int unsigned NT = 32;
`ifdef ERROR_REPORT_SUMMARY_EN
  localparam int EXP_LEN  = 358;
  localparam int EXP2_LEN = 34;
`else
  localparam int EXP_LEN  = 352;
  localparam int EXP2_LEN = 28;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic            I_STB;
  logic [CW*NT-1:0] I_DAT;
  logic            O_STB;
  logic [7:0]      O_DAT;
  logic            O_RDY;
  logic            BUSY;
  logic [7:0]      DROP_CNT;

  logic            s_stb;
  logic [31:0]     s_dat;
  logic            s_ostb;
  logic [7:0]      s_odat;
  logic            s_rdy;
  logic            s_busy;
  logic [7:0]      s_drop;

  int n_total = 0;
  int n_pass  = 0;
  int unstable;
  int last_cyc;
  logic [CW*NT-1:0] frame_dat;
  logic [7:0] cap [0:1023];
  logic [7:0] cap2 [0:127];
  string exp_s;
  string exp2_s;

  always #5 CLK = ~CLK;

  error_report_formatter #(.COUNT_WIDTH(CW), .DELAY_TAPS(NT)) dut (
    .CLK(CLK), .RST(RST), .I_STB(I_STB), .I_DAT(I_DAT),
    .O_STB(O_STB), .O_DAT(O_DAT), .O_RDY(O_RDY),
    .BUSY(BUSY), .DROP_CNT(DROP_CNT)
  );

  error_report_formatter #(.COUNT_WIDTH(8), .DELAY_TAPS(4)) dut_small (
    .CLK(CLK), .RST(RST), .I_STB(s_stb), .I_DAT(s_dat),
    .O_STB(s_ostb), .O_DAT(s_odat), .O_RDY(s_rdy),
    .BUSY(s_busy), .DROP_CNT(s_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic string hexc(input logic [3:0] n);
    return (n < 10) ? $sformatf("%c", 8'd48 + 8'(n)) : $sformatf("%c", 8'd55 + 8'(n));
  endfunction

  function automatic int mism(input int n);
    int bad = 0;
    if (n != exp_s.len()) bad++;
    for (int i = 0; i < n && i < exp_s.len(); i++)
      if (cap[i] !== 8'(exp_s[i])) bad++;
    return bad;
  endfunction

  task automatic start();
    I_STB = 1'b1;
    @(negedge CLK);
    I_STB = 1'b0;
  endtask

  // Called at a negedge with a frame running; consumes bytes until BUSY drops,
  // stop_after bytes have transferred, or the cycle budget expires.
  task automatic run_frame(input bit rnd, input int pulses, input bit end_stb,
                           input int stop_after, output int n);
    logic [7:0] pd;
    logic pend;
    int cyc;
    n = 0; pend = 1'b0; pd = '0; cyc = 0; unstable = 0;
    while (cyc < 4000) begin
      if (pend && ((O_STB !== 1'b1) || (O_DAT !== pd))) unstable++;
      if (BUSY !== 1'b1) break;
      if (n == stop_after) break;
      I_STB = (cyc >= 2) && (cyc < 2 + pulses);
      I_DAT = I_STB ? '1 : frame_dat;
      O_RDY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (end_stb && O_RDY && O_STB && (n == EXP_LEN - 1)) I_STB = 1'b1;
      if (O_STB && O_RDY) begin
        cap[n] = O_DAT;
        n++;
      end
      pend = O_STB && !O_RDY;
      pd   = O_DAT;
      @(negedge CLK);
      cyc++;
    end
    I_STB = 1'b0;
    I_DAT = frame_dat;
    O_RDY = 1'b1;
    last_cyc = cyc;
  endtask

  initial begin
    int n;
    int d0;
    logic [CW-1:0] c;

    // Expected text for the main frame: tap0=00000A, tap1=123ABC, rest zero.
    exp_s = "";
    for (int t = 0; t < NT; t++) begin
      logic [7:0] tb;
      tb = 8'(t);
      c  = (t == 0) ? 24'h00000A : (t == 1) ? 24'h123ABC : 24'h0;
      exp_s = {exp_s, hexc(tb[7:4]), hexc(tb[3:0]), ":"};
      for (int k = 5; k >= 0; k--) exp_s = {exp_s, hexc(4'(c >> (4 * k)))};
      exp_s = {exp_s, "\r\n"};
    end
`ifdef ERROR_REPORT_SUMMARY_EN
    exp_s = {exp_s, "B:02\r\n"};
`endif
    exp2_s = "00:05\r\n01:02\r\n02:02\r\n03:09\r\n";
`ifdef ERROR_REPORT_SUMMARY_EN
    exp2_s = {exp2_s, "B:01\r\n"};
`endif

    frame_dat = '0;
    frame_dat[CW*NT-1 -: CW] = 24'h00000A;
    frame_dat[CW*NT-CW-1 -: CW] = 24'h123ABC;
    RST = 1'b1; I_STB = 1'b0; I_DAT = frame_dat; O_RDY = 1'b1;
    s_stb = 1'b0; s_dat = {8'd5, 8'd2, 8'd2, 8'd9}; s_rdy = 1'b1;
    repeat (3) @(negedge CLK);

    chk("rst_ostb", 32'(O_STB), 32'd0);
    chk("rst_odat", 32'(O_DAT), 32'h00);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_drop", 32'(DROP_CNT), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: full frame at one byte per cycle
    start();
    chk("s1_latency_ostb", 32'(O_STB), 32'd1);
    chk("s1_first_byte", 32'(O_DAT), 32'h30);
    run_frame(1'b0, 0, 1'b0, -1, n);
    chk("s1_timeout", 32'(last_cyc < 4000), 32'd1);
    chk("s1_len", 32'(n), 32'(EXP_LEN));
    chk("s1_mismatch", 32'(mism(n)), 32'd0);
    chk("s1_l0_digitA", 32'(cap[8]), 32'h41);
    chk("s1_l1_C", 32'(cap[19]), 32'h43);
    chk("s1_l31_F", 32'(cap[342]), 32'h46);
    chk("s1_busy_end", 32'(BUSY), 32'd0);
    chk("s1_ostb_end", 32'(O_STB), 32'd0);
    @(negedge CLK);

    // 2: random back-pressure
    start();
    run_frame(1'b1, 0, 1'b0, -1, n);
    chk("s2_timeout", 32'(last_cyc < 4000), 32'd1);
    chk("s2_mismatch", 32'(mism(n)), 32'd0);
    chk("s2_stable", 32'(unstable), 32'd0);
    @(negedge CLK);

    // 3: strobes while busy are counted and ignored
    start();
    run_frame(1'b0, 3, 1'b0, -1, n);
    chk("s3_drop3", 32'(DROP_CNT), 32'd3);
    chk("s3_mismatch", 32'(mism(n)), 32'd0);
    @(negedge CLK);
    start();
    run_frame(1'b0, 300, 1'b0, -1, n);
    chk("s3_drop_sat", 32'(DROP_CNT), 32'hFF);
    chk("s3_mismatch2", 32'(mism(n)), 32'd0);
    @(negedge CLK);

    // 4: reset mid-frame, then restart from tap 0
    start();
    run_frame(1'b0, 0, 1'b0, 20, n);
    chk("s4_pre_cnt", 32'(n), 32'd20);
    chk("s4_pre_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("s4_rst_ostb", 32'(O_STB), 32'd0);
    chk("s4_rst_busy", 32'(BUSY), 32'd0);
    chk("s4_rst_drop", 32'(DROP_CNT), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    start();
    run_frame(1'b0, 0, 1'b0, -1, n);
    chk("s4_restart_b0", 32'(cap[0]), 32'h30);
    chk("s4_restart_b2", 32'(cap[2]), 32'h3A);
    chk("s4_mismatch", 32'(mism(n)), 32'd0);

    // 6: strobe on the final transfer is dropped; next cycle is accepted
    @(negedge CLK);
    start();
    d0 = int'(DROP_CNT);
    run_frame(1'b0, 0, 1'b1, -1, n);
    chk("s6_len", 32'(n), 32'(EXP_LEN));
    chk("s6_drop", 32'(DROP_CNT), 32'(d0 + 1));
    chk("s6_idle_ostb", 32'(O_STB), 32'd0);
    start();
    chk("s6_new_ostb", 32'(O_STB), 32'd1);
    chk("s6_new_busy", 32'(BUSY), 32'd1);
    chk("s6_new_byte", 32'(O_DAT), 32'h30);
    run_frame(1'b0, 0, 1'b0, -1, n);
    chk("s6_mismatch", 32'(mism(n)), 32'd0);

    // 5: small instance, 4 taps of 8 bits
    @(negedge CLK);
    s_stb = 1'b1;
    @(negedge CLK);
    s_stb = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (!s_busy) break;
      if (s_ostb) begin
        cap2[n] = s_odat;
        n++;
      end
      @(negedge CLK);
    end
    chk("s5_len", 32'(n), 32'(EXP2_LEN));
    chk("s5_busy_end", 32'(s_busy), 32'd0);
    begin
      int bad = 0;
      for (int i = 0; i < n && i < exp2_s.len(); i++)
        if (cap2[i] !== 8'(exp2_s[i])) bad++;
      chk("s5_mismatch", 32'(bad), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
